// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall unit feeding the EX-stage operand muxes.
// Keeps a shadow of the ID/EX and EX/MEM destination state; sels register at the ID->EX edge.
module fwd_hazard_unit #(
   parameter int RBITS = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [RBITS-1:0] id_rs,
   input  logic [RBITS-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic [RBITS-1:0] id_rd,
   input  logic             id_regwrite,
   input  logic             id_memread,
   input  logic             ex_flush,
   output logic             fwd_a_sel1,
   output logic             fwd_a_sel2,
   output logic             fwd_b_sel1,
   output logic             fwd_b_sel2,
   output logic             stall,
   output logic [CNT_W-1:0] stall_count
);

   logic [RBITS-1:0] ex_rd_q, ex_rd_d, mem_rd_q, mem_rd_d;
   logic             ex_regwrite_q, ex_regwrite_d;
   logic             ex_memread_q, ex_memread_d;
   logic             mem_regwrite_q, mem_regwrite_d;
   logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             bubble;

   // {sel1,sel2}: 01 = EX/MEM result, 10 = MEM/WB data; the newer producer wins.
   function automatic logic [1:0] fwd_sel(
      input logic [RBITS-1:0] src,
      input logic [RBITS-1:0] e_rd,
      input logic             e_wr,
      input logic [RBITS-1:0] m_rd,
      input logic             m_wr
   );
      if (e_wr && e_rd != '0 && e_rd == src)      return 2'b01;
      else if (m_wr && m_rd != '0 && m_rd == src) return 2'b10;
      return 2'b00;
   endfunction

   always_comb begin
      stall = id_valid && ex_regwrite_q && ex_memread_q && (ex_rd_q != '0) &&
              ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));
   end

   always_comb begin
      bubble         = stall || ex_flush || !id_valid;
      mem_rd_d       = ex_rd_q;
      mem_regwrite_d = ex_regwrite_q;
      ex_rd_d        = '0;
      ex_regwrite_d  = 1'b0;
      ex_memread_d   = 1'b0;
      fwd_a_d        = 2'b00;
      fwd_b_d        = 2'b00;
      if (!bubble) begin
         ex_rd_d       = id_rd;
         ex_regwrite_d = id_regwrite;
         ex_memread_d  = id_memread;
         fwd_a_d = fwd_sel(id_rs, ex_rd_q, ex_regwrite_q, mem_rd_q, mem_regwrite_q);
         if (id_uses_rt)
            fwd_b_d = fwd_sel(id_rt, ex_rd_q, ex_regwrite_q, mem_rd_q, mem_regwrite_q);
      end
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != '1)
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_rd_q        <= '0;
         ex_regwrite_q  <= 1'b0;
         ex_memread_q   <= 1'b0;
         mem_rd_q       <= '0;
         mem_regwrite_q <= 1'b0;
         fwd_a_q        <= 2'b00;
         fwd_b_q        <= 2'b00;
         stall_count_q  <= '0;
      end else begin
         ex_rd_q        <= ex_rd_d;
         ex_regwrite_q  <= ex_regwrite_d;
         ex_memread_q   <= ex_memread_d;
         mem_rd_q       <= mem_rd_d;
         mem_regwrite_q <= mem_regwrite_d;
         fwd_a_q        <= fwd_a_d;
         fwd_b_q        <= fwd_b_d;
         stall_count_q  <= stall_count_d;
      end
   end

   assign fwd_a_sel1  = fwd_a_q[1];
   assign fwd_a_sel2  = fwd_a_q[0];
   assign fwd_b_sel1  = fwd_b_q[1];
   assign fwd_b_sel2  = fwd_b_q[0];
   assign stall_count = stall_count_q;

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Forwarding-control and load-use hazard stage that sits directly upstream of the EX-stage operand muxes, one mux per ALU operand.
- Mux select encoding is {sel1,sel2}:
  - 00 selects d1, the register-file operand.
  - 01 selects d2, the EX/MEM ALU result.
  - 10 selects d3, the MEM/WB writeback data.
  - 11 is illegal and is never driven by this block.
- The block keeps its own shadow copy of destination-register state for the ID/EX and EX/MEM stages.
- It registers the select bits at the ID->EX edge, so they are valid for the whole EX cycle.
- It raises a load-use stall toward IF/ID.

Parameters:
- RBITS, 5, register-specifier width.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs  in  RBITS  source register A of the ID instruction.
- id_rt  in  RBITS  source register B of the ID instruction.
- id_uses_rt  in  1  the ID instruction reads rt as an operand.
- id_rd  in  RBITS  destination register of the ID instruction.
- id_regwrite  in  1  the ID instruction writes the register file.
- id_memread  in  1  the ID instruction is a load.
- ex_flush  in  1  kill the instruction entering EX (branch or jump).
- fwd_a_sel1  out  1  operand-A mux sel1, registered.
- fwd_a_sel2  out  1  operand-A mux sel2, registered.
- fwd_b_sel1  out  1  operand-B mux sel1, registered.
- fwd_b_sel2  out  1  operand-B mux sel2, registered.
- stall  out  1  combinational; hold PC and IF/ID, insert a bubble.
- stall_count  out  CNT_W  saturating count of stall cycles, registered.

Behaviour:
- Reset is synchronous, active-high, and dominates all other inputs:
  - ex_rd, ex_regwrite, ex_memread, mem_rd and mem_regwrite are all cleared to 0.
  - All four sel outputs go to 0.
  - stall_count goes to 0.
  - stall therefore reads 0 in the cycle after reset.
- Internal shadow state:
  - ID/EX entry: ex_rd, ex_regwrite, ex_memread.
  - EX/MEM entry: mem_rd, mem_regwrite.
- stall is combinational:
  - stall = id_valid & ex_regwrite & ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt))).
- Every edge without reset:
  - mem_* <= ex_*. The downstream pipeline always advances, even during a stall.
- Bubble case: if stall, ex_flush or !id_valid on an edge:
  - ex_regwrite <= 0 and ex_memread <= 0; ex_rd <= 0.
  - All sel outputs <= 0.
- Issue case (otherwise):
  - ex_* <= id_*.
  - Sel outputs are computed from the pre-edge shadow state.
- Operand-A select, first match wins:
  - ex_regwrite & ex_rd != 0 & ex_rd == id_rs gives {0,1}. That instruction moves to MEM on this edge, so its result is on d2.
  - Else mem_regwrite & mem_rd != 0 & mem_rd == id_rs gives {1,0}. That instruction moves to WB, so its data is on d3.
  - Else {0,0}.
- Operand-B select:
  - Same rule using id_rt.
  - Forced to {0,0} when id_uses_rt = 0.
- Priority: the newer producer (EX/MEM) always beats the older one (MEM/WB) when both match.
- Register 0 is never forwarded and never causes a stall.
- A load in ID/EX with a matching consumer always stalls, so sel 01 never selects a load's address.
- After one stall cycle the load sits in EX/MEM shadow and the consumer receives {1,0}.
- Hazards three or more instructions back are resolved by the write-first register file; they are out of scope here.
- ex_flush together with stall: a bubble is inserted, and stall_count still increments.
- stall_count increments by 1 on each edge where stall = 1 and reset = 0. It holds at 2^CNT_W - 1 (saturates).
- Latency:
  - Sel outputs are one cycle after the ID presentation, aligned with EX.
  - stall is zero latency.

Test Plan:
1. Reset with id_valid=1, id_rs=8, id_rd=8 held for 2 cycles -> all sel 0, stall 0, stall_count 0.
2. I1 rd=8 regwrite, then I2 rs=8 rt=9 uses_rt -> in I2's EX cycle a={0,1}, b={0,0}, stall 0.
3. I1 rd=8, I2 rd=10, I3 rs=9 rt=8 uses_rt -> in I3's EX cycle a={0,0}, b={1,0}. With id_uses_rt=0 instead, b={0,0}.
4. I1 rd=8, I2 rd=8, I3 rs=8 -> in I3's EX cycle a={0,1} (newer producer wins).
5. I1 load rd=8, I2 rs=8:
   - stall=1 for exactly one cycle; the bubble cycle has sel 0; stall_count=1.
   - I2 then enters EX with a={1,0}.
   - Preload stall_count at 0xFFFF via a long stall -> it stays at 0xFFFF.
6. I1 rd=0 regwrite, then I2 rs=0 -> sel 0, no stall. Then I1 rd=8 entering with ex_flush=1, I2 rs=8 -> a={0,0}, because the flushed instruction never forwards.
